// File: rtl/test_status_responder.sv
// Watches the core's store stream for a pass/abort marker and latches a sticky verdict,
// with a cycle watchdog and a memory-mapped status word for software polling.
module test_status_responder #(
  parameter int          CNT_W      = 10,
  parameter int          TIMEOUT    = 48,
  parameter logic [63:0] PASS_ADR0  = 64'd84,
  parameter logic [63:0] PASS_DAT0  = 64'd7,
  parameter logic [63:0] PASS_ADR1  = 64'd128,
  parameter logic [63:0] PASS_DAT1  = 64'd7,
  parameter logic [63:0] PASS_ADR2  = 64'd80,
  parameter logic [63:0] PASS_DAT2  = 64'd1,
  parameter logic [63:0] ABORT_ADR  = 64'd252,
  parameter logic [63:0] STATUS_ADR = 64'd248
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       memwrite,
  input  logic [63:0]      dataadr,
  input  logic [63:0]      writedata,
  output logic             status_hit,
  output logic [63:0]      status_rdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       test_id,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  localparam logic [2:0][63:0] ENTRY_ADR = {PASS_ADR2, PASS_ADR1, PASS_ADR0};
  localparam logic [2:0][63:0] ENTRY_DAT = {PASS_DAT2, PASS_DAT1, PASS_DAT0};
  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT > (1 << CNT_W)) begin : g_timeout_check
    $error("TIMEOUT does not fit in a CNT_W-bit cycle counter");
  end

  state_t           state_reg, state_next;
  logic [1:0]       test_id_reg, test_id_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic             store;
  logic [2:0]       entry_hit;

  assign store = |memwrite;

  for (genvar gi = 0; gi < 3; gi++) begin : g_entry
    assign entry_hit[gi] = store && (dataadr == ENTRY_ADR[gi]) && (writedata == ENTRY_DAT[gi]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_RUN;
      test_id_reg <= 2'd0;
      cycles_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      test_id_reg <= test_id_next;
      cycles_reg  <= cycles_next;
    end
  end

  // Priority: lowest matching entry, then abort, then watchdog; the verdict edge is not counted.
  always_comb begin
    state_next   = state_reg;
    test_id_next = test_id_reg;
    cycles_next  = cycles_reg;
    if (state_reg == ST_RUN) begin
      if (entry_hit[0]) begin
        state_next   = ST_PASS;
        test_id_next = 2'd0;
      end else if (entry_hit[1]) begin
        state_next   = ST_PASS;
        test_id_next = 2'd1;
      end else if (entry_hit[2]) begin
        state_next   = ST_PASS;
        test_id_next = 2'd2;
      end else if (store && (dataadr == ABORT_ADR)) begin
        state_next   = ST_FAIL;
        test_id_next = 2'd3;
      end else if (cycles_reg == LAST_CYCLE) begin
        state_next   = ST_FAIL;
        test_id_next = 2'd0;
      end else begin
        cycles_next  = cycles_reg + 1'b1;
      end
    end
  end

  assign done    = (state_reg != ST_RUN);
  assign pass    = (state_reg == ST_PASS);
  assign fail    = (state_reg == ST_FAIL);
  assign test_id = test_id_reg;
  assign cycles  = cycles_reg;

  assign status_hit = (dataadr == STATUS_ADR);

  always_comb begin
    status_rdata = '0;
    if (status_hit) begin
      status_rdata[1:0]          = state_reg;
      status_rdata[3:2]          = test_id_reg;
      status_rdata[16 +: CNT_W]  = cycles_reg;
    end
  end

endmodule

// File: tb/tb_test_status_responder.sv
// Randomized store streams against an edge-counting verdict model, plus the directed
// scenarios: sticky pass, wrong data, timeout, pass-on-last-cycle, abort, async reset.
module tb_test_status_responder;

  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 48;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       memwrite;
  logic [63:0]      dataadr;
  logic [63:0]      writedata;
  logic             status_hit;
  logic [63:0]      status_rdata;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       test_id;
  logic [CNT_W-1:0] cycles;

  test_status_responder dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .dataadr      (dataadr),
    .writedata    (writedata),
    .status_hit   (status_hit),
    .status_rdata (status_rdata),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .test_id      (test_id),
    .cycles       (cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] pass_adr [3] = '{64'd84, 64'd128, 64'd80};
  logic [63:0] pass_dat [3] = '{64'd7, 64'd7, 64'd1};

  // Model: verdict 0=running 1=pass 2=fail; edges = rising edges seen since reset release.
  int m_verdict, m_tid, m_cyc, m_edges;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_verdict = 0; m_tid = 0; m_cyc = 0; m_edges = 0;
  endtask

  // While running, cycles equals edges seen; the deciding edge leaves it at edges-1.
  task automatic model_edge(input logic [1:0] mw, input logic [63:0] adr, input logic [63:0] dat);
    int idx;
    if (m_verdict != 0) return;
    m_edges++;
    idx = -1;
    for (int i = 0; i < 3; i++)
      if (idx < 0 && mw != 0 && adr == pass_adr[i] && dat == pass_dat[i]) idx = i;
    if (idx >= 0) begin
      m_verdict = 1; m_tid = idx; m_cyc = m_edges - 1;
    end else if (mw != 0 && adr == 64'd252) begin
      m_verdict = 2; m_tid = 3; m_cyc = m_edges - 1;
    end else if (m_edges == TIMEOUT) begin
      m_verdict = 2; m_tid = 0; m_cyc = TIMEOUT - 1;
    end else begin
      m_cyc = m_edges;
    end
  endtask

  task automatic check_all();
    logic [63:0] exp_rd;
    exp_rd = (dataadr == 64'd248) ?
             ((64'(m_cyc) << 16) | (64'(m_tid) << 2) | 64'(m_verdict)) : 64'd0;
    check("done",    64'(done),    64'(m_verdict != 0));
    check("pass",    64'(pass),    64'(m_verdict == 1));
    check("fail",    64'(fail),    64'(m_verdict == 2));
    check("test_id", 64'(test_id), 64'(m_tid));
    check("cycles",  64'(cycles),  64'(m_cyc));
    check("status_hit",   64'(status_hit), 64'(dataadr == 64'd248));
    check("status_rdata", status_rdata, exp_rd);
  endtask

  task automatic step(input logic [1:0] mw, input logic [63:0] adr, input logic [63:0] dat);
    memwrite = mw; dataadr = adr; writedata = dat;
    @(posedge clk); #1;
    model_edge(mw, adr, dat);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 64'd0, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1; memwrite = 2'd0; dataadr = 64'd0; writedata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_all();
  endtask

  task automatic report(input string name);
    $display("[TB] %s: verdict=%0d test_id=%0d cycles=%0d", name, m_verdict, m_tid, m_cyc);
  endtask

  task automatic random_op(output logic [1:0] mw, output logic [63:0] adr, output logic [63:0] dat);
    int r, k;
    r = $urandom_range(0, 99);
    k = $urandom_range(0, 2);
    mw = 2'($urandom_range(1, 3));
    if (r < 3) begin
      adr = pass_adr[k]; dat = pass_dat[k];
    end else if (r < 9) begin
      adr = pass_adr[k]; dat = pass_dat[k] ^ (64'd1 << $urandom_range(0, 63));
    end else if (r < 11) begin
      adr = 64'd252; dat = {$urandom, $urandom};
    end else if (r < 17) begin
      mw = 2'd0; adr = pass_adr[k]; dat = pass_dat[k];
    end else if (r < 27) begin
      mw = 2'($urandom_range(0, 3)); adr = 64'd248; dat = {$urandom, $urandom};
    end else if (r < 33) begin
      adr = pass_adr[k] | (64'd1 << $urandom_range(32, 63)); dat = pass_dat[k];
    end else begin
      mw = 2'($urandom_range(0, 3)); adr = {$urandom, $urandom}; dat = {$urandom, $urandom};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mw;
    logic [63:0] adr, dat;

    // Sticky pass on entry 0 at cycle 10.
    do_reset();
    idle(10);
    step(2'd1, 64'd84, 64'd7);
    check("pass_cycles10", 64'(cycles), 64'd10);
    idle(3);
    step(2'd2, 64'd252, 64'd0);
    report("store 84/7 at cycle 10");

    // Wrong data ignored, then entry 1.
    do_reset();
    step(2'd1, 64'd128, 64'd6);
    step(2'd1, 64'd128, 64'd7);
    check("entry1_id", 64'(test_id), 64'd1);
    report("store 128/6 then 128/7");

    // Timeout, then a late pass store is ignored.
    do_reset();
    idle(TIMEOUT);
    check("timeout_cycles", 64'(cycles), 64'(TIMEOUT - 1));
    step(2'd1, 64'd80, 64'd1);
    step(2'd0, 64'd248, 64'd0);
    report("timeout then 80/1");

    // Pass store on the last counted cycle beats the watchdog.
    do_reset();
    idle(TIMEOUT - 1);
    step(2'd3, 64'd80, 64'd1);
    check("last_cycle_pass", 64'(pass), 64'd1);
    report("store 80/1 on cycle TIMEOUT-1");

    // Abort at cycle 5, then poll the status word.
    do_reset();
    idle(5);
    step(2'd1, 64'd252, 64'hDEAD);
    step(2'd0, 64'd248, 64'd0);
    check("abort_status", status_rdata, 64'h0005_000E);
    report("abort at cycle 5");

    // Asynchronous reset between edges, then non-store matches never pass.
    do_reset();
    idle(20);
    #3 reset = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step(2'd0, 64'd84, 64'd7);
    report("async reset mid-run");

    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int c = 0; c < TIMEOUT + 8; c++) begin
        random_op(mw, adr, dat);
        step(mw, adr, dat);
      end
      report($sformatf("random run %0d", run));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
